// File: rtl/hangman_pkg.sv
// Shared keypad definitions for the hangman input stage: key indices, ASCII
// constants, scan FSM states and multi-tap group lookups.
package hangman_pkg;

  // Key index is {row, col} with R0/C0 as index 0.
  typedef enum logic [3:0] {
    KEY_1    = 4'd0,
    KEY_2    = 4'd1,
    KEY_3    = 4'd2,
    KEY_A    = 4'd3,
    KEY_4    = 4'd4,
    KEY_5    = 4'd5,
    KEY_6    = 4'd6,
    KEY_B    = 4'd7,
    KEY_7    = 4'd8,
    KEY_8    = 4'd9,
    KEY_9    = 4'd10,
    KEY_C    = 4'd11,
    KEY_STAR = 4'd12,
    KEY_0    = 4'd13,
    KEY_HASH = 4'd14,
    KEY_D    = 4'd15
  } key_e;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} scan_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_0     = 8'h30;

  localparam key_e KEY_SUBMIT = KEY_STAR;
  localparam key_e KEY_WORD   = KEY_0;
  localparam key_e KEY_CLEAR  = KEY_HASH;

  function automatic logic [7:0] group_base(input key_e key);
    case (key)
      KEY_2:   return ASCII_A;
      KEY_3:   return ASCII_A + 8'd3;
      KEY_4:   return ASCII_A + 8'd6;
      KEY_5:   return ASCII_A + 8'd9;
      KEY_6:   return ASCII_A + 8'd12;
      KEY_7:   return ASCII_A + 8'd15;
      KEY_8:   return ASCII_A + 8'd19;
      KEY_9:   return ASCII_A + 8'd22;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] group_size(input key_e key);
    case (key)
      KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_8: return 3'd3;
      KEY_7, KEY_9:                             return 3'd4;
      default:                                  return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] key_digit(input key_e key);
    case (key)
      KEY_1:   return ASCII_0 + 8'd1;
      KEY_2:   return ASCII_0 + 8'd2;
      KEY_3:   return ASCII_0 + 8'd3;
      KEY_4:   return ASCII_0 + 8'd4;
      KEY_5:   return ASCII_0 + 8'd5;
      KEY_6:   return ASCII_0 + 8'd6;
      KEY_7:   return ASCII_0 + 8'd7;
      KEY_8:   return ASCII_0 + 8'd8;
      KEY_9:   return ASCII_0 + 8'd9;
      KEY_0:   return ASCII_0;
      default: return 8'h00;
    endcase
  endfunction

  // Bit3 of a row/column vector is line 0.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0100: return 2'd1;
      4'b0010: return 2'd2;
      4'b0001: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchroniser plus consecutive-sample counter; flags the sample on which a
// one-hot pattern (press) or an all-zero pattern (release) becomes stable.
module keypad_debounce
  import hangman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_row_raw,
  input  logic       i_sample_en,
  output logic [3:0] o_row,
  output logic       o_onehot,
  output logic       o_same,
  output logic       o_press,
  output logic       o_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    r_sync1, r_sync2, r_pat;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_pat   <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_row_raw;
      r_sync2 <= r_sync1;
      // Samples are meaningless while disabled, so the run length restarts.
      if (!i_sample_en) begin
        r_pat <= 4'd0;
        r_cnt <= '0;
      end else begin
        r_pat <= r_sync2;
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign o_row      = r_sync2;
  assign o_onehot   = (r_sync2 != 4'd0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'd0);
  assign o_same     = (r_sync2 == r_pat) && (r_cnt != '0);
  assign w_cnt_next = !o_same ? CW'(1) : (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
  assign w_hit      = i_sample_en && (w_cnt_next == CNT_MAX) && !(o_same && r_cnt == CNT_MAX);
  assign o_press    = w_hit && o_onehot;
  assign o_release  = w_hit && (r_sync2 == 4'd0);

endmodule

// File: rtl/keypad_multitap_encoder.sv
// Keypad column scanner with phone-style multi-tap letter composition.
// Define KEYPAD_DIGIT_TAP_EN to append each key's digit as a final tap position.
module keypad_multitap_encoder
  import hangman_pkg::*;
#(
  parameter int SCAN_DIV           = 4,
  parameter int DEBOUNCE_CYCLES    = 2,
  parameter int TAP_TIMEOUT_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] pending_char,
  output logic       pending_valid,
  output logic [7:0] letter_char,
  output logic       letter_strobe,
  output logic       clear_strobe,
  output logic       word_strobe
);
  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // The first two row samples after a column change still reflect the old column.
  localparam logic [DIV_W-1:0] DIV_SETTLE = DIV_W'(2);
  localparam int TAP_W = $clog2(TAP_TIMEOUT_CYCLES + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(TAP_TIMEOUT_CYCLES);

  scan_state_e      r_state;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_col;
  logic [TAP_W-1:0] r_tap_cnt;
  logic             r_tap_run;
  logic             r_pend_valid;
  logic [7:0]       r_pend_char, r_letter_char;
  key_e             r_last_key;
  logic [2:0]       r_tap_idx;
  logic             r_letter_strobe, r_clear_strobe, r_word_strobe;

  logic [3:0] w_row;
  logic       w_onehot, w_same, w_press, w_release;
  logic       w_sample_en, w_key_evt, w_rel_evt, w_same_group;
  key_e       w_key;
  logic [2:0] w_letters, w_size, w_idx_next;
  logic [7:0] w_tap_char;

  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_row_raw  (row_in),
    .i_sample_en(w_sample_en),
    .o_row      (w_row),
    .o_onehot   (w_onehot),
    .o_same     (w_same),
    .o_press    (w_press),
    .o_release  (w_release)
  );

  assign w_sample_en = (r_state != SCAN) || (r_div >= DIV_SETTLE);
  assign w_key_evt   = w_press && (r_state == SCAN || r_state == DEB_PRESS);
  assign w_rel_evt   = w_release && (r_state == PRESSED || r_state == DEB_REL);
  assign w_key       = key_e'({onehot_idx(w_row), onehot_idx(r_col)});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN;
      r_div   <= '0;
      r_col   <= 4'b1000;
    end else begin
      case (r_state)
        SCAN: begin
          if (w_sample_en && w_onehot) begin
            r_state <= w_press ? PRESSED : DEB_PRESS;
          end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_col <= {r_col[0], r_col[3:1]};
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (w_press) begin
            r_state <= PRESSED;
          end else if (!w_same) begin
            r_state <= SCAN;
            r_div   <= '0;
          end
        end
        PRESSED: begin
          if (w_row == 4'd0) begin
            if (w_release) begin
              r_state <= SCAN;
              r_div   <= '0;
            end else begin
              r_state <= DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (w_row != 4'd0) begin
            r_state <= PRESSED;
          end else if (w_release) begin
            r_state <= SCAN;
            r_div   <= '0;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  always_comb begin
    w_letters = group_size(w_key);
`ifdef KEYPAD_DIGIT_TAP_EN
    w_size = (key_digit(w_key) != 8'h00 && w_key != KEY_WORD) ? w_letters + 3'd1 : 3'd0;
`else
    w_size = w_letters;
`endif
    w_same_group = r_pend_valid && (w_key == r_last_key) && (r_tap_cnt != TAP_MAX);
    if (!w_same_group || r_tap_idx == w_size - 3'd1) begin
      w_idx_next = 3'd0;
    end else begin
      w_idx_next = r_tap_idx + 3'd1;
    end
`ifdef KEYPAD_DIGIT_TAP_EN
    w_tap_char = (w_idx_next == w_letters) ? key_digit(w_key)
                                           : group_base(w_key) + {5'd0, w_idx_next};
`else
    w_tap_char = group_base(w_key) + {5'd0, w_idx_next};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap_cnt       <= '0;
      r_tap_run       <= 1'b0;
      r_pend_valid    <= 1'b0;
      r_pend_char     <= ASCII_SPACE;
      r_last_key      <= KEY_1;
      r_tap_idx       <= 3'd0;
      r_letter_char   <= 8'h00;
      r_letter_strobe <= 1'b0;
      r_clear_strobe  <= 1'b0;
      r_word_strobe   <= 1'b0;
    end else begin
      r_letter_strobe <= 1'b0;
      r_clear_strobe  <= 1'b0;
      r_word_strobe   <= 1'b0;
      // The tap timer only runs between a release and the next key event.
      if (w_key_evt) begin
        r_tap_cnt <= '0;
        r_tap_run <= 1'b0;
      end else if (w_rel_evt) begin
        r_tap_run <= 1'b1;
      end else if (r_tap_run && r_tap_cnt != TAP_MAX) begin
        r_tap_cnt <= r_tap_cnt + 1'b1;
      end
      if (w_key_evt) begin
        if (w_key == KEY_SUBMIT) begin
          if (r_pend_valid) begin
            r_letter_char   <= r_pend_char;
            r_letter_strobe <= 1'b1;
          end
          r_pend_valid <= 1'b0;
          r_pend_char  <= ASCII_SPACE;
        end else if (w_key == KEY_CLEAR) begin
          r_pend_valid   <= 1'b0;
          r_pend_char    <= ASCII_SPACE;
          r_clear_strobe <= 1'b1;
        end else if (w_key == KEY_WORD) begin
          r_word_strobe <= 1'b1;
        end else if (w_size != 3'd0) begin
          r_pend_valid <= 1'b1;
          r_pend_char  <= w_tap_char;
          r_last_key   <= w_key;
          r_tap_idx    <= w_idx_next;
        end
      end
    end
  end

  assign col_out       = r_col;
  assign pending_char  = r_pend_char;
  assign pending_valid = r_pend_valid;
  assign letter_char   = r_letter_char;
  assign letter_strobe = r_letter_strobe;
  assign clear_strobe  = r_clear_strobe;
  assign word_strobe   = r_word_strobe;

endmodule

// File: doc/keypad_multitap_encoder.md
Name: keypad_multitap_encoder

Overview:
Upstream input stage for the hangman game controller; one instance per keypad (host and player).
- Scans the 4x4 matrix keypad and debounces key presses.
- Converts phone-style multi-tap presses into an ASCII pending letter.
- Emits one-cycle strobes for letter submit, pending clear and word submit, which the game FSM and LCD row builder consume.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven before advancing (no key held)
DEBOUNCE_CYCLES, 2, consecutive identical row samples required to accept a press or release
TAP_TIMEOUT_CYCLES, 100, idle cycles after a release before a same-key tap restarts the group (1 s at 100 Hz)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
row_in  in  4  keypad rows, active-high; bit3=R0 ... bit0=R3
col_out  out  4  one-hot column drive; bit3=C0 ... bit0=C3
pending_char  out  8  ASCII of the letter being composed; 8'h20 when none
pending_valid  out  1  a pending letter exists
letter_char  out  8  ASCII of the submitted letter, valid with letter_strobe
letter_strobe  out  1  one-cycle pulse: pending letter submitted
clear_strobe  out  1  one-cycle pulse: pending letter discarded
word_strobe  out  1  one-cycle pulse: word submit key accepted

Behaviour:
- Reset: col_out=4'b1000, pending_char=8'h20, pending_valid=0, letter_char=8'h00, all strobes=0, scan FSM=SCAN, tap counter cleared.
- row_in passes through a 2-flop synchroniser before any use.
- Scan FSM states and transitions:
  - SCAN: rotate col_out C0->C1->C2->C3->C0 every SCAN_DIV cycles. Any nonzero synced row -> DEB_PRESS, column frozen.
  - DEB_PRESS: the same one-hot row pattern for DEBOUNCE_CYCLES samples -> PRESSED and one key event (row, col) is issued. A pattern change or zero row -> SCAN.
  - PRESSED: column held. Zero row -> DEB_REL.
  - DEB_REL: zero row for DEBOUNCE_CYCLES samples -> SCAN, and the tap timer starts. A nonzero row -> PRESSED, with no new event.
- More than one row bit set: not one-hot, no event, remain or return to SCAN.
- Key map (row, col):
  - R0: 1, 2=ABC, 3=DEF, A
  - R1: 4=GHI, 5=JKL, 6=MNO, B
  - R2: 7=PQRS, 8=TUV, 9=WXYZ, C
  - R3: *=submit letter, 0=submit word, #=clear, D
- Letter key, no pending letter: pending = first letter of group, tap index 0.
- Same key again while pending and before the timer expires: tap index increments, wrapping to 0 after the last letter. Wrap order: ABC->A, PQRS->P.
- Same key after timeout: pending restarts at first letter of group.
- Different letter key: pending replaced by first letter of new group.
- Keys 1, A, B, C, D: ignored; pending unchanged.
- *: if pending_valid, letter_char=pending_char and letter_strobe=1 for one cycle; pending clears the same cycle. If nothing pending, no strobe.
- #: pending cleared; clear_strobe pulses even if nothing was pending.
- 0: word_strobe pulses; pending unchanged.
- Latency: outputs and strobes update on the clk edge after the debounce-accept cycle. Maximum one event per physical press.
- Tap timer saturates at TAP_TIMEOUT_CYCLES; it is cleared by every key event.
- Reset mid-press clears all state. A key still held is treated as a fresh press after reset.

Optional Feature:
KEYPAD_DIGIT_TAP_EN.
- Defined: each letter group gets its key digit appended as an extra tap position, e.g. A,B,C,'2' then wrap. Key 1 yields '1'; key 0 still acts as word submit.
- Undefined: letters only, as described above.

Decomposition:
- hangman_pkg holds: key index enum (KEY_1..KEY_D); ASCII constants (ASCII_SPACE, ASCII_A); group base-letter and group-size lookup functions; KEY_SUBMIT, KEY_WORD, KEY_CLEAR localparams.
- One sub-module, keypad_debounce: synchroniser, counter, stable-pattern compare. It outputs press/release pulses.
- Scan FSM and multi-tap logic stay in the top level.

Test Plan:
- Hold R0 at C1 for 10 cycles, release, then press * -> pending 'A' -> letter_char=8'h41, letter_strobe one cycle, pending_char=8'h20.
- Three R1C1 taps, 20 cycles apart, then * -> 'L' (8'h4C) submitted. A fourth tap before * -> 'J' (wrap).
- R2C0 twice with 150 idle cycles between -> pending 'P' both times (timeout restart).
- R0C1 then R1C0 -> pending 'G'. Then # -> clear_strobe, pending_valid=0. Then * -> no letter_strobe.
- 1-cycle glitch on row_in and a 2-row press (4'b1100) -> no event, col_out keeps rotating.
- Assert rst while R3C1 is held, deassert -> no word_strobe until debounce completes, then exactly one word_strobe.
